dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the CPU's MEM-stage load/store interface: accepts one
//   word read or write request at a time and holds it for LATENCY cycles of modelled
//   memory delay. Returns read data with a one-cycle response strobe.
//   Drives stall_o so the pipeline freezes IF..MEM while an access is outstanding.
//   Sits between EX_MEM outputs (ALU address, store data, MemRead/MemWrite) and MEM_WB.ReadData.
// PARAMETERS
//   DEPTH_WORDS  256  number of 32-bit words in the backing array (power of 2)
//   LATENCY      3    cycles from request accept to array access; legal range 1..15
//   DATA_W       32   data width (fixed at 32 for this CPU)
// PORTS
//   clk_i          in   1       clock; all state updates on rising edge
//   rst_i          in   1       asynchronous, active-high reset
//   req_valid_i    in   1       request present (MemRead | MemWrite from EX_MEM)
//   req_we_i       in   1       1 = store, 0 = load
//   req_addr_i     in   32      byte address (ALU result)
//   req_wdata_i    in   32      store data
//   req_ready_o    out  1       responder can accept a request this cycle
//   rsp_valid_o    out  1       one-cycle strobe: access complete
//   rsp_rdata_o    out  32      load data; valid while rsp_valid_o=1
//   rsp_err_o      out  1       misaligned-access flag (see CONFIGURATION)
//   stall_o        out  1       freeze PC/IF_ID/ID_EX/EX_MEM this cycle
// BEHAVIOUR
//   - Reset: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0,
//     stall_o=0, counter=0. Array contents are NOT reset.
//   - FSM IDLE -> BUSY -> RESP -> IDLE.
//     IDLE: req_ready_o=1. If req_valid_i=1: latch we/addr/wdata and load cnt=LATENCY-1.
//       Then go BUSY.
//     BUSY: if cnt!=0, decrement. If cnt==0, perform the array access and go RESP:
//       - write: array[idx] <= wdata
//       - read: rdata register <= array[idx]
//     RESP: rsp_valid_o=1 for exactly one cycle, then go IDLE.
//   - LATENCY=1: BUSY lasts one cycle. Load-to-rsp_valid_o latency = LATENCY+1 cycles
//     after the accept edge.
//   - req_ready_o=1 only in IDLE. Throughput is one request per LATENCY+2 cycles.
//   - stall_o = (IDLE & req_valid_i) | BUSY (combinational).
//     It is 0 in RESP, so the pipeline advances on the same edge MEM_WB captures rsp_rdata_o.
//   - Write response: rsp_rdata_o=0. A request on the first IDLE cycle after RESP is a
//     new access; the CPU guarantees EX_MEM has advanced by then.
//   - Address: idx = req_addr_i[2 +: $clog2(DEPTH_WORDS)]. Bits [1:0] and the upper
//     bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
//   - Request inputs are sampled only at accept. Changes during BUSY/RESP are ignored.
//   - Reset mid-operation (BUSY or RESP): the pending access is dropped, with no array
//     write and no rsp_valid_o. Outputs take their reset values immediately.
// CONFIGURATION
//   Macro DMEM_MISALIGN_TRAP_EN.
//   Defined:
//     - A request with req_addr_i[1:0]!=0 is accepted and timed normally.
//     - No array write and no array read occur.
//     - In RESP: rsp_err_o=1, rsp_rdata_o=0.
//   Undefined:
//     - rsp_err_o is tied 0.
//     - Low address bits are silently truncated and the access proceeds.
// STRUCTURE
//   Shared package cpu_pkg:
//     - dmem_state_t enum {IDLE, BUSY, RESP}
//     - DMEM_LAT_MAX=15
//     - WORD_BYTES=4
//   Sub-module dmem_sram:
//     - DEPTH_WORDS x 32 array
//     - synchronous write and registered read, both on the one access cycle
//   Top level holds the FSM, the 4-bit latency counter and the request latches.
// TESTING
//   1 Reset -> req_ready_o=1, rsp_valid_o=0, stall_o=0, rsp_err_o=0, rsp_rdata_o=0.
//   2 LATENCY=3: store 0xDEADBEEF @0x10, then load @0x10.
//     -> stall_o=1 for 4 cycles per access; rsp_valid_o pulses once per access;
//        the load returns 0xDEADBEEF.
//   3 Store 0x12345678 @0x400 with DEPTH_WORDS=256, then load @0x000
//     -> 0x12345678 (wrap).
//   4 Assert rst_i during BUSY of a store 0xAAAA5555 @0x20, then load @0x20
//     -> old value returned; no rsp_valid_o for the aborted store.
//   5 LATENCY=1: back-to-back loads with req_valid_i held
//     -> accepts are 3 cycles apart; rsp_valid_o is never high for 2 consecutive cycles.
//   6 DMEM_MISALIGN_TRAP_EN: store @0x13 -> rsp_err_o=1 with rsp_valid_o.
//     A following load @0x10 returns unchanged data.
//     Without the macro, the store @0x13 writes word 0x10 and rsp_err_o=0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared CPU types and constants used by the data-memory responder.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;
  localparam int DMEM_LAT_MAX = 15;
  localparam int DMEM_CNT_W   = 4;
  localparam int WORD_BYTES   = 4;
endpackage

// File: rtl/dmem_sram.sv
// Word-addressed backing array: synchronous write and registered read on the access cycle.
module dmem_sram #(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_W      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [DATA_W-1:0]              i_wdata,
  output logic [DATA_W-1:0]              o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (i_en && i_we) r_mem[i_idx] <= i_wdata;
  end

  // A write access leaves zero in the read register so write responses carry no data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_rdata <= '0;
    else if (i_en) r_rdata <= i_we ? '0 : r_mem[i_idx];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding access, LATENCY-cycle modelled delay.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3,
  parameter int DATA_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_t           r_state;
  logic [DMEM_CNT_W-1:0] r_cnt;
  logic                  r_we;
  logic [AW-1:0]         r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_ready;
  logic                  r_rsp_valid;
  logic                  w_access;
  logic                  w_en;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_unused_addr;

  assign w_access      = (r_state == BUSY) && (r_cnt == '0);
  assign w_unused_addr = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_mis;
  logic r_err;

  // A misaligned access keeps its timing but never touches the array.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mis <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && req_valid_i) r_mis <= (req_addr_i[1:0] != 2'b00);
      r_err <= w_access && r_mis;
    end
  end

  assign w_en        = w_access && !r_mis;
  assign rsp_err_o   = r_err;
  assign rsp_rdata_o = (r_rsp_valid && !r_mis) ? w_rdata : '0;
`else
  assign w_en        = w_access;
  assign rsp_err_o   = 1'b0;
  assign rsp_rdata_o = r_rsp_valid ? w_rdata : '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_we    <= req_we_i;
            r_idx   <= req_addr_i[2 +: AW];
            r_wdata <= req_wdata_i;
            r_cnt   <= LAT_M1;
            r_ready <= 1'b0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Low in RESP so the pipeline advances on the edge MEM_WB captures the load data.
  assign stall_o     = ((r_state == IDLE) && req_valid_i) || (r_state == BUSY);
  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W)
  ) u_sram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_en   (w_en),
    .i_we   (r_we),
    .i_idx  (r_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus random accesses against a word-array model.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int L3    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v3 = 0, we3 = 0;
  logic [31:0] a3 = 0, wd3 = 0;
  logic        rdy3, rv3, err3, st3;
  logic [31:0] rd3;

  logic        v1 = 0, we1 = 0;
  logic [31:0] a1 = 0, wd1 = 0;
  logic        rdy1, rv1, err1, st1;
  logic [31:0] rd1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L3), .DATA_W(32)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_we_i(we3), .req_addr_i(a3),
    .req_wdata_i(wd3), .req_ready_o(rdy3), .rsp_valid_o(rv3), .rsp_rdata_o(rd3),
    .rsp_err_o(err3), .stall_o(st3));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .DATA_W(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_we_i(we1), .req_addr_i(a1),
    .req_wdata_i(wd1), .req_ready_o(rdy1), .rsp_valid_o(rv1), .rsp_rdata_o(rd1),
    .rsp_err_o(err1), .stall_o(st1));

  int passes = 0;
  int total  = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One complete access on dut3; inputs are scrambled after accept to prove they are latched.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag, output logic [31:0] rd, output logic err);
    int   stalls = 0, pulses = 0, rcyc = -1, readies = 0;
    int   idx;
    bit   mis, exp_err;
    logic [31:0] exp_rd;
    idx     = (addr / 4) % DEPTH;
    mis     = (addr % 4) != 0;
    exp_err = TRAP && mis;
    rd      = 'x;
    err     = 'x;
    v3 = 1; we3 = we; a3 = addr; wd3 = wdata;
    for (int c = 0; c < L3 + 3; c++) begin
      @(negedge clk);
      if (st3)  stalls++;
      if (rdy3) readies++;
      if (rv3) begin pulses++; rcyc = c; rd = rd3; err = err3; end
      @(posedge clk); #1;
      if (c == 0) begin v3 = 0; we3 = $urandom; a3 = $urandom; wd3 = $urandom; end
    end
    check({tag, ".stall"}, stalls, L3 + 1);
    check({tag, ".ready"}, readies, 2);
    check({tag, ".pulses"}, pulses, 1);
    check({tag, ".rcyc"}, rcyc, L3 + 1);
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    if (we || exp_err) check({tag, ".rdata0"}, rd, 32'h0);
    else if (known[idx]) begin
      exp_rd = ref_mem[idx];
      check({tag, ".rdata"}, rd, exp_rd);
    end
    if (we && !exp_err) begin ref_mem[idx] = wdata; known[idx] = 1; end
  endtask

  initial begin
    logic [31:0] rd, old10;
    logic        er;
    int          cnt, acc, rsps, stalls, consec, first_rsp, last_acc, gap_bad;
    logic        prev_rv;

    // Reset state
    #12;
    check("rst.ready", rdy3, 1);
    check("rst.rv", rv3, 0);
    check("rst.stall", st3, 0);
    check("rst.err", err3, 0);
    check("rst.rdata", rd3, 0);
    @(posedge clk); #1; rst = 0;

    // Store then load with LATENCY=3
    access(1, 32'h10, 32'hDEADBEEF, "st10", rd, er);
    access(0, 32'h10, 32'h0, "ld10", rd, er);
    check("ld10.val", rd, 32'hDEADBEEF);

    // Address wrap
    access(1, 32'h400, 32'h12345678, "st400", rd, er);
    access(0, 32'h000, 32'h0, "ld000", rd, er);
    check("wrap.val", rd, 32'h12345678);

    // Reset during BUSY of a store drops it
    access(1, 32'h20, 32'h11112222, "st20", rd, er);
    v3 = 1; we3 = 1; a3 = 32'h20; wd3 = 32'hAAAA5555;
    @(posedge clk); #1; v3 = 0;
    @(posedge clk); #1; rst = 1;
    #1;
    check("midrst.ready", rdy3, 1);
    check("midrst.stall", st3, 0);
    check("midrst.rv", rv3, 0);
    check("midrst.rdata", rd3, 0);
    @(posedge clk); #1; rst = 0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv3) cnt++;
    end
    check("midrst.norsp", cnt, 0);
    @(posedge clk); #1;
    access(0, 32'h20, 32'h0, "ld20", rd, er);
    check("midrst.old", rd, 32'h11112222);

    // Misaligned store
    access(0, 32'h10, 32'h0, "ld10b", rd, er);
    old10 = rd;
    access(1, 32'h13, 32'hCAFEF00D, "st13", rd, er);
    check("mis.err", {31'b0, er}, {31'b0, TRAP});
    access(0, 32'h10, 32'h0, "ld10c", rd, er);
    check("mis.after", rd, TRAP ? old10 : 32'hCAFEF00D);

    // LATENCY=1 back-to-back loads with valid held
    @(posedge clk); #1;
    v1 = 1; we1 = 0; a1 = $urandom;
    acc = 0; rsps = 0; stalls = 0; consec = 0; first_rsp = -1; last_acc = -1; gap_bad = 0;
    prev_rv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rdy1) begin
        if (last_acc >= 0 && c - last_acc != 3) gap_bad++;
        last_acc = c; acc++;
      end
      if (rv1) begin
        rsps++;
        if (first_rsp < 0) first_rsp = c;
        if (prev_rv) consec++;
      end
      if (st1) stalls++;
      prev_rv = rv1;
      @(posedge clk); #1; a1 = $urandom;
    end
    v1 = 0;
    check("lat1.accepts", acc, 4);
    check("lat1.gap", gap_bad, 0);
    check("lat1.rsps", rsps, 4);
    check("lat1.first", first_rsp, 2);
    check("lat1.consec", consec, 0);
    check("lat1.stalls", stalls, 8);

    // Random accesses against the model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 3) == 0) ra = ra | $urandom_range(1, 3);
      access(1'($urandom_range(0, 1)), ra, $urandom, $sformatf("rnd%0d", n), rd, er);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    total++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passes, total);
    $fatal(1, "watchdog");
  end
endmodule
